seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/seg_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment glyph constants for the scan decoder and display driver
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-high gfedcba patterns
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef logic [2:0] digit_idx_t;
    typedef logic [NUM_DIGITS-1:0] digit_mask_t;

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational seven-segment pattern to hex nibble decoder
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            // Blank and every unlisted pattern are rejected as non-hex
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - dwell-filtered multiplexed display snooper, optional SEG_DP_CAPTURE_EN
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        clk_rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic [7:0]  digit_err,
    output logic        data_changed,
    output logic [7:0]  dp_out
);

    localparam logic [7:0] DWELL_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] DWELL_CAP = 8'(STABLE_CYCLES - 1);
    localparam logic       POL_INV   = (SEG_ACTIVE_LOW != 0);

    digit_idx_t  which_q, which_d, prev_which_q;
    logic [7:0]  seg_q, seg_d, prev_seg_q;
    logic [7:0]  dwell_q, dwell_d;
    digit_mask_t mask_q, mask_d, mask_set;
    logic [31:0] shadow_nib_q, shadow_nib_d;
    logic [7:0]  shadow_err_q, shadow_err_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        changed_q, changed_d;

    logic        pair_changed;
    logic        capture;
    logic        frame_done;
    logic [6:0]  glyph;
    logic [3:0]  dec_nib;
    logic        dec_err;

    assign which_d = which;

`ifdef SEG_DP_CAPTURE_EN
    assign seg_d = seg;
`else
    // dp is forced to zero before registering so a dp-only toggle never restarts the dwell
    logic unused_dp_bit;
    assign unused_dp_bit = seg[7];
    assign seg_d = {1'b0, seg[6:0]};
`endif

    assign glyph = seg_q[6:0] ^ {7{POL_INV}};

    seg7_to_hex u_seg7_to_hex (
        .pattern (glyph),
        .nibble  (dec_nib),
        .err     (dec_err)
    );

    always_comb begin
        pair_changed = (which_q != prev_which_q) || (seg_q != prev_seg_q);
        dwell_d      = dwell_q;
        if (pair_changed) begin
            dwell_d = 8'd0;
        end else if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + 8'd1;
        end
        // Fire only on the transition into the capture count so a long dwell captures once
        capture = (dwell_d == DWELL_CAP) && (dwell_q != DWELL_CAP);
    end

    always_comb begin
        mask_set     = mask_q | (digit_mask_t'(1) << which_q);
        mask_d       = mask_q;
        shadow_nib_d = shadow_nib_q;
        shadow_err_d = shadow_err_q;
        frame_done   = 1'b0;
        if (capture) begin
            shadow_nib_d[{which_q, 2'b00} +: 4] = dec_nib;
            shadow_err_d[which_q]               = dec_err;
            frame_done                          = (mask_set == '1);
            mask_d                              = frame_done ? '0 : mask_set;
        end
    end

    always_comb begin
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        if (frame_done) begin
            data_d    = shadow_nib_d;
            err_d     = shadow_err_d;
            valid_d   = 1'b1;
            changed_d = (shadow_nib_d != data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            which_q      <= '0;
            seg_q        <= '0;
            prev_which_q <= '0;
            prev_seg_q   <= '0;
            dwell_q      <= '0;
            mask_q       <= '0;
            shadow_nib_q <= '0;
            shadow_err_q <= '0;
            data_q       <= '0;
            err_q        <= '0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            which_q      <= which_d;
            seg_q        <= seg_d;
            prev_which_q <= which_q;
            prev_seg_q   <= seg_q;
            dwell_q      <= dwell_d;
            mask_q       <= mask_d;
            shadow_nib_q <= shadow_nib_d;
            shadow_err_q <= shadow_err_d;
            data_q       <= data_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            changed_q    <= changed_d;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic [7:0] shadow_dp_q, shadow_dp_d;
    logic [7:0] dp_q, dp_d;

    always_comb begin
        shadow_dp_d = shadow_dp_q;
        dp_d        = dp_q;
        if (capture) begin
            shadow_dp_d[which_q] = seg_q[7] ^ POL_INV;
        end
        if (frame_done) begin
            dp_d = shadow_dp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            shadow_dp_q <= '0;
            dp_q        <= '0;
        end else begin
            shadow_dp_q <= shadow_dp_d;
            dp_q        <= dp_d;
        end
    end

    assign dp_out = dp_q;
`else
    assign dp_out = 8'h00;
`endif

    assign data_out     = data_q;
    assign digit_err    = err_q;
    assign data_valid   = valid_q;
    assign data_changed = changed_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized bench with frame-level reference model for seg_scan_decoder
`timescale 1ns/1ps
module tb_seg_scan_decoder;

    localparam int S = 4;
`ifdef SEG_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clk_rst = 1'b1;
    logic [2:0]  which = 3'd0;
    logic [7:0]  seg = 8'h00;
    logic [7:0]  seg_inv;

    logic [31:0] d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_chg, d1_chg;
    logic [7:0]  d0_err, d1_err, d0_dp, d1_dp;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign seg_inv = ~seg;

    seg_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(0)) u_dut0 (
        .clk(clk), .clk_rst(clk_rst), .which(which), .seg(seg),
        .data_out(d0_data), .data_valid(d0_valid), .digit_err(d0_err),
        .data_changed(d0_chg), .dp_out(d0_dp)
    );

    seg_scan_decoder #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .clk_rst(clk_rst), .which(which), .seg(seg_inv),
        .data_out(d1_data), .data_valid(d1_valid), .digit_err(d1_err),
        .data_changed(d1_chg), .dp_out(d1_dp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a value seen S consecutive samples is captured once; reset counts as two zero samples
    int          runlen = 2;
    logic [2:0]  run_w = 3'd0;
    logic [7:0]  run_s = 8'h00;
    logic [31:0] m_nib = 32'h0;
    logic [7:0]  m_err = 8'h0, m_dp = 8'h0, m_mask = 8'h0;
    logic [31:0] e_data = 32'h0;
    logic [7:0]  e_err = 8'h0, e_dp = 8'h0;
    logic        e_valid = 1'b0, e_changed = 1'b0;

    task automatic model_capture();
        logic [3:0] nib;
        logic       er;
        nib = 4'h0;
        er  = 1'b1;
        for (int g = 0; g < 16; g++) begin
            if (glyph_tab[g] == run_s[6:0]) begin
                nib = 4'(g);
                er  = 1'b0;
            end
        end
        m_nib[int'(run_w) * 4 +: 4] = nib;
        m_err[run_w]  = er;
        m_dp[run_w]   = DP_EN ? run_s[7] : 1'b0;
        m_mask[run_w] = 1'b1;
        if (m_mask == 8'hFF) begin
            e_valid   = 1'b1;
            e_changed = (m_nib != e_data);
            e_data    = m_nib;
            e_err     = m_err;
            e_dp      = m_dp;
            m_mask    = 8'h00;
        end
    endtask

    task automatic model_step();
        logic [7:0] s_key;
        s_key = DP_EN ? seg : {1'b0, seg[6:0]};
        if (clk_rst) begin
            runlen = 2; run_w = 3'd0; run_s = 8'h00;
            m_nib = 32'h0; m_err = 8'h0; m_dp = 8'h0; m_mask = 8'h0;
            e_data = 32'h0; e_err = 8'h0; e_dp = 8'h0; e_valid = 1'b0; e_changed = 1'b0;
        end else begin
            e_valid   = 1'b0;
            e_changed = 1'b0;
            if (runlen == S) model_capture();
            if (which == run_w && s_key == run_s) begin
                if (runlen < 1000) runlen++;
            end else begin
                run_w  = which;
                run_s  = s_key;
                runlen = 1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    int          nvalid = 0;
    int          valid_cyc = 0;
    int          present_cyc = 0;
    logic [31:0] snap0_data = 32'h0, snap1_data = 32'h0;
    logic [7:0]  snap0_err = 8'h0, snap0_dp = 8'h0, snap1_dp = 8'h0;
    logic        snap0_chg = 1'b0;

    always @(negedge clk) begin
        check("d0_valid", 32'(d0_valid), 32'(e_valid));
        check("d0_data", d0_data, e_data);
        check("d0_err", 32'(d0_err), 32'(e_err));
        check("d0_dp", 32'(d0_dp), 32'(e_dp));
        check("d0_changed", 32'(d0_chg), 32'(e_changed));
        check("d1_valid", 32'(d1_valid), 32'(e_valid));
        check("d1_data", d1_data, e_data);
        check("d1_err", 32'(d1_err), 32'(e_err));
        check("d1_dp", 32'(d1_dp), 32'(e_dp));
        check("d1_changed", 32'(d1_chg), 32'(e_changed));
        if (d0_valid) begin
            nvalid++;
            valid_cyc  = cyc;
            snap0_data = d0_data;
            snap0_err  = d0_err;
            snap0_dp   = d0_dp;
            snap0_chg  = d0_chg;
        end
        if (d1_valid) begin
            snap1_data = d1_data;
            snap1_dp   = d1_dp;
        end
    end

    task automatic present(input logic [2:0] w, input logic [7:0] s, input int n);
        @(negedge clk);
        which       = w;
        seg         = s;
        present_cyc = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic frame(input logic [63:0] pats, input int dwell);
        for (int k = 0; k < 8; k++) present(3'(k), pats[8 * k +: 8], dwell);
        repeat (3) @(negedge clk);
    endtask

    localparam logic [63:0] P_8765 = 64'h7F_07_7D_6D_66_4F_5B_06;
    localparam logic [63:0] P_BLANK5 = 64'h7F_07_00_6D_66_4F_5B_06;
    localparam logic [63:0] P_DEAD = 64'h5E_79_77_5E_7C_79_79_71;
    localparam logic [63:0] P_DP0 = 64'h7F_07_7D_6D_66_4F_5B_86;

    int nv;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", d0_data, 32'h0);
        check("rst_valid", 32'(d0_valid), 32'h0);
        check("rst_err", 32'(d0_err), 32'h0);
        check("rst_dp", 32'(d0_dp), 32'h0);
        check("rst_changed", 32'(d0_chg), 32'h0);
        clk_rst = 1'b0;

        nv = nvalid;
        frame(P_8765, 6);
        check("f1_count", 32'(nvalid - nv), 32'd1);
        check("f1_data", snap0_data, 32'h87654321);
        check("f1_err", 32'(snap0_err), 32'h00);
        check("f1_changed", 32'(snap0_chg), 32'd1);
        check("f1_latency", 32'(valid_cyc - present_cyc), 32'(S + 1));
        check("f1_inv_data", snap1_data, 32'h87654321);

        nv = nvalid;
        frame(P_8765, 6);
        check("f2_count", 32'(nvalid - nv), 32'd1);
        check("f2_data", snap0_data, 32'h87654321);
        check("f2_changed", 32'(snap0_chg), 32'd0);

        nv = nvalid;
        for (int k = 0; k < 8; k++) present(3'(k), P_8765[8 * k +: 8], (k == 3) ? 3 : 6);
        repeat (6) @(negedge clk);
        check("short3_count", 32'(nvalid - nv), 32'd0);
        present(3'd3, 8'h4F, 6);
        repeat (3) @(negedge clk);
        check("short3_fix_count", 32'(nvalid - nv), 32'd1);
        check("short3_latency", 32'(valid_cyc - present_cyc), 32'(S + 1));

        frame(P_BLANK5, 6);
        check("blank_data", snap0_data, 32'h87054321);
        check("blank_err", 32'(snap0_err), 32'h20);
        check("blank_changed", 32'(snap0_chg), 32'd1);

        for (int k = 0; k < 5; k++) present(3'(k), P_8765[8 * k +: 8], 6);
        @(negedge clk);
        clk_rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", d0_data, 32'h0);
        check("midrst_err", 32'(d0_err), 32'h0);
        clk_rst = 1'b0;
        nv = nvalid;
        for (int k = 0; k < 7; k++) present(3'(k), P_DEAD[8 * k +: 8], 6);
        repeat (3) @(negedge clk);
        check("dead_early_count", 32'(nvalid - nv), 32'd0);
        present(3'd7, P_DEAD[63:56], 6);
        repeat (3) @(negedge clk);
        check("dead_count", 32'(nvalid - nv), 32'd1);
        check("dead_data", snap0_data, 32'hDEADBEEF);
        check("dead_changed", 32'(snap0_chg), 32'd1);

        frame(P_DP0, 6);
        check("dp_data", snap0_data, 32'h87654321);
        check("dp_inv_data", snap1_data, 32'h87654321);
        check("dp_out", 32'(snap0_dp), DP_EN ? 32'h01 : 32'h00);
        check("dp_inv_out", 32'(snap1_dp), DP_EN ? 32'h01 : 32'h00);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] w;
            logic [7:0] s;
            int d;
            w = ($urandom_range(0, 9) < 8) ? 3'(i % 8) : 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                : {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 15)]};
            d = $urandom_range(1, 7);
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                clk_rst = 1'b1;
                @(negedge clk);
                clk_rst = 1'b0;
            end
            if (d >= 4 && $urandom_range(0, 3) == 0) begin
                present(w, s, 2);
                present(w, s ^ 8'h80, d - 2);
            end else begin
                present(w, s, d);
            end
        end
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
